// File: rtl/seq_mult_param.sv
// Sequential digit-serial multiplier: one DIGIT x DIGIT partial product per cycle, accumulated into a 2*WIDTH result.
// Optional macro SIGNED_MODE_EN adds the sgn port for two's-complement operands (sign-magnitude with negation on completion).
module seq_mult_param #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
  input  logic               sgn,
`endif
  output logic [2*WIDTH-1:0] answer,
  output logic               busy,
  output logic               done
);

  localparam int ND = WIDTH / DIGIT;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(ND - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     answer_q, answer_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sgn_in;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [PW-1:0]     pp_shifted;

`ifdef SIGNED_MODE_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // Operands are stored as magnitudes; -2^(WIDTH-1) maps onto itself, which reads correctly as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic signed_op);
    return (signed_op && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic negate);
    return negate ? (~v + PW'(1)) : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    neg_d    = neg_q;
    answer_d = answer_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    a_dig      = a_q[int'(i_q)*DIGIT +: DIGIT];
    b_dig      = b_q[int'(j_q)*DIGIT +: DIGIT];
    pp         = (2*DIGIT)'(a_dig) * (2*DIGIT)'(b_dig);
    pp_shifted = PW'(pp) << (DIGIT * (int'(i_q) + int'(j_q)));

    case (state_q)
      IDLE: begin
        if (st) begin
          a_d     = magnitude(a, sgn_in);
          b_d     = magnitude(b, sgn_in);
          neg_d   = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) state_d = FIN;
          else             i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      FIN: begin
        answer_d = apply_sign(acc_q, neg_q);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      neg_q    <= 1'b0;
      answer_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      neg_q    <= neg_d;
      answer_q <= answer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign answer = answer_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: a 16/4 instance and an 8/4 instance on a shared clock and reset.
module tb_seq_mult_param;

  logic        clk;
  logic        rst;
  logic        st16, st8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic        sgn16, sgn8;
  logic [31:0] answer16;
  logic [15:0] answer8;
  logic        busy16, done16, busy8, done8;

  int tests;
  int fails;
  logic [31:0] q16[$];
  logic [15:0] q8[$];

  seq_mult_param #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .st(st16), .a(a16), .b(b16),
`ifdef SIGNED_MODE_EN
    .sgn(sgn16),
`endif
    .answer(answer16), .busy(busy16), .done(done16)
  );

  seq_mult_param #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst(rst), .st(st8), .a(a8), .b(b8),
`ifdef SIGNED_MODE_EN
    .sgn(sgn8),
`endif
    .answer(answer8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model16(input logic [15:0] av, input logic [15:0] bv, input logic sg);
    longint p;
    if (sg) p = longint'($signed(av)) * longint'($signed(bv));
    else    p = longint'({48'b0, av}) * longint'({48'b0, bv});
    return p[31:0];
  endfunction

  // One 16-bit operation: pushes the expectation, starts, optionally pokes st at cycle poke_n, checks latency/busy/done/answer.
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sg,
                       input logic [31:0] expv, input int poke_n);
    int n, bc, dc;
    logic [31:0] got_exp;
    q16.push_back(expv);
    @(negedge clk);
    a16 = av; b16 = bv; sgn16 = sg; st16 = 1'b1;
    n = 0; bc = 0; dc = 0;
    while (n < 40 && dc == 0) begin
      @(negedge clk);
      n++;
      st16 = (n == poke_n);
      if (n == 1) begin
        a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~sg;
      end
      if (busy16) bc++;
      if (done16) dc++;
    end
    tests++;
    if (dc != 1) begin fails++; $display("FAIL run16_timeout: done count %0d, expected 1", dc); end
    tests++;
    if (n != 18) begin fails++; $display("FAIL run16_latency: done at cycle %0d, expected 18", n); end
    tests++;
    if (bc != 17) begin fails++; $display("FAIL run16_busy_cycles: %0d, expected 17", bc); end
    got_exp = (q16.size() > 0) ? q16.pop_front() : 32'hx;
    tests++;
    if (answer16 !== got_exp) begin
      fails++; $display("FAIL run16_answer: a=%h b=%h got %h expected %h", av, bv, answer16, got_exp);
    end
    @(negedge clk);
    tests++;
    if (done16 !== 1'b0 || answer16 !== got_exp) begin
      fails++; $display("FAIL run16_done_pulse_hold: done=%b answer=%h expected done=0 answer=%h", done16, answer16, got_exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; st16 = 1'b1; st8 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; a8 = 8'hFF; b8 = 8'hFF; sgn16 = 1'b0; sgn8 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (answer16 !== 32'h0) begin fails++; $display("FAIL reset_answer: got %h expected 0", answer16); end
    tests++;
    if (busy16 !== 1'b0 || busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b/%b expected 0", busy16, busy8); end
    tests++;
    if (done16 !== 1'b0 || done8 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b/%b expected 0", done16, done8); end
    st16 = 1'b0; st8 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (busy16 !== 1'b0) begin fails++; $display("FAIL reset_release_idle: busy %b expected 0", busy16); end
  endtask

  task automatic test_max;
    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);
  endtask

  task automatic test_back_to_back;
    int dc;
    run16(16'h1234, 16'h0000, 1'b0, 32'h00000000, 5);
    run16(16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD, 9);
    dc = 0;
    repeat (30) begin
      @(negedge clk);
      if (done16) dc++;
    end
    tests++;
    if (dc != 0 || busy16 !== 1'b0) begin
      fails++; $display("FAIL back_to_back_extra_done: dones %0d busy %b, expected 0/0", dc, busy16);
    end
  endtask

  task automatic test_st_held;
    int n, dc, n1, n2;
    logic [31:0] e;
    q16.push_back(32'd21);
    q16.push_back(32'd21);
    @(negedge clk);
    a16 = 16'd3; b16 = 16'd7; sgn16 = 1'b0; st16 = 1'b1;
    n = 0; dc = 0; n1 = 0; n2 = 0;
    while (n < 60 && dc < 2) begin
      @(negedge clk);
      n++;
      if (done16) begin
        dc++;
        if (dc == 1) n1 = n; else begin n2 = n; st16 = 1'b0; end
        e = (q16.size() > 0) ? q16.pop_front() : 32'hx;
        tests++;
        if (answer16 !== e) begin fails++; $display("FAIL st_held_answer: got %h expected %h", answer16, e); end
      end
    end
    st16 = 1'b0;
    tests++;
    if (dc != 2 || n1 != 18 || n2 - n1 != 18) begin
      fails++; $display("FAIL st_held_restart: dones %0d at %0d,%0d expected 2 at 18,36", dc, n1, n2);
    end
    @(negedge clk);
    tests++;
    if (busy16 !== 1'b0) begin fails++; $display("FAIL st_held_stop: busy %b expected 0", busy16); end
  endtask

  task automatic test_width8;
    int n, dc;
    logic [15:0] e;
    q8.push_back(16'h4E20);
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; sgn8 = 1'b0; st8 = 1'b1;
    n = 0; dc = 0;
    while (n < 20 && dc == 0) begin
      @(negedge clk);
      n++;
      st8 = 1'b0;
      if (n == 1) begin a8 = 8'd1; b8 = 8'd1; end
      if (done8) dc++;
    end
    e = (q8.size() > 0) ? q8.pop_front() : 16'hx;
    tests++;
    if (dc != 1 || n != 6) begin fails++; $display("FAIL w8_latency: done %0d at cycle %0d expected 1 at 6", dc, n); end
    tests++;
    if (answer8 !== e) begin fails++; $display("FAIL w8_answer: got %h expected %h", answer8, e); end
  endtask

  task automatic test_reset_abort;
    int dc;
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h00FF; sgn16 = 1'b0; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (answer16 !== 32'h0 || busy16 !== 1'b0) begin
      fails++; $display("FAIL abort_immediate: answer %h busy %b expected 0/0", answer16, busy16);
    end
    @(negedge clk);
    rst = 1'b1;
    dc = 0;
    repeat (25) begin
      @(negedge clk);
      if (done16 || busy16) dc++;
    end
    tests++;
    if (dc != 0) begin fails++; $display("FAIL abort_no_done: %0d active cycles expected 0", dc); end
    run16(16'h0102, 16'h0304, 1'b0, 32'h00030A08, 0);
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run16(ra, rb, 1'b0, model16(ra, rb, 1'b0), 0);
    end
  endtask

`ifdef SIGNED_MODE_EN
  task automatic test_signed;
    run16(16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1, 0);
    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
    run16(16'hFFFD, 16'd5, 1'b0, 32'h0004FFF1, 0);
    run16(16'h8000, 16'h0003, 1'b1, model16(16'h8000, 16'h0003, 1'b1), 0);
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_max;
    test_back_to_back;
    test_st_held;
    test_width8;
    test_reset_abort;
    test_random;
`ifdef SIGNED_MODE_EN
    test_signed;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of DIGIT, at least 2*DIGIT.
REQ-002 The module SHALL have parameter DIGIT, default 4, partial-product digit width in bits (DIGIT x DIGIT multiplier core).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port st  input  1  start request, sampled on rising clk.
REQ-006 Port a  input  WIDTH  multiplicand, captured when a start is accepted.
REQ-007 Port b  input  WIDTH  multiplier, captured when a start is accepted.
REQ-008 Port sgn  input  1  signed-operand select; present only when SIGNED_MODE_EN is defined.
REQ-009 Port answer  output  2*WIDTH  product of the last completed operation, registered.
REQ-010 Port busy  output  1  high while an operation is in progress.
REQ-011 Port done  output  1  single-cycle pulse marking answer update.

Function
REQ-012 Definitions: ND = WIDTH/DIGIT digits per operand; NP = ND*ND partial products per operation.
REQ-013 FSM SHALL have states IDLE, CALC, FIN; reset state IDLE.
REQ-014 IDLE: st=1 at an edge SHALL capture a and b (and sgn), clear accumulator, clear digit indices i=j=0, and enter CALC; st=0 stays IDLE.
REQ-015 CALC: each cycle SHALL add (a_digit[i] * b_digit[j]) << (DIGIT*(i+j)) to a 2*WIDTH accumulator, then advance j; on j wrap to 0, i increments.
REQ-016 CALC SHALL last exactly NP cycles, then enter FIN after the last partial product (i=j=ND-1) is accumulated.
REQ-017 FIN: SHALL load answer from the accumulator, pulse done for one cycle, and return to IDLE on the next edge.
REQ-018 Latency: start accepted at edge k -> answer valid and done=1 in the cycle after edge k+NP+1; 17 edges at defaults.
REQ-019 busy SHALL be 1 in CALC and FIN and 0 in IDLE.
REQ-020 st asserted while busy=1 SHALL be ignored; no queueing. st held high continuously SHALL restart on the first IDLE cycle after done.
REQ-021 Changes on a/b after capture SHALL NOT affect the running operation.
REQ-022 answer SHALL hold its value between done pulses and change only in FIN.
REQ-023 Accumulation SHALL be exact modulo 2^(2*WIDTH); the unsigned product never overflows 2*WIDTH bits.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, answer=0, busy=0, done=0, accumulator, indices and captured operands to 0, independent of clk.
REQ-025 Reset during CALC or FIN SHALL abort the operation; no done pulse is produced for it.
REQ-026 st SHALL be ignored while rst=0; the first start is accepted on the first edge with rst=1 and st=1.

Configuration
REQ-027 With macro SIGNED_MODE_EN defined, the sgn port SHALL exist.
REQ-028 If sgn=1 at capture, a and b SHALL be treated as two's complement. Capture SHALL store magnitudes and the result sign (a[MSB] XOR b[MSB]). FIN SHALL negate the accumulator when that sign is 1. Latency SHALL be unchanged.
REQ-029 Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); it fits WIDTH unsigned bits and SHALL produce the correct signed product.
REQ-030 Without SIGNED_MODE_EN, sgn SHALL not exist and all operation SHALL be unsigned.

Verification
REQ-031 Defaults, a=16'hFFFF, b=16'hFFFF, st pulse -> busy for 17 cycles, done once, answer=32'hFFFE0001.
REQ-032 Defaults, a=16'h1234, b=16'h0000, then a=16'h0001, b=16'hABCD back-to-back -> answers 32'h00000000 then 32'h0000ABCD. Each has a one-cycle done. st pulses during busy produce no extra done.
REQ-033 WIDTH=8, DIGIT=4, a=8'd200, b=8'd100 -> done 5 edges after start, answer=16'h4E20.
REQ-034 rst driven low mid-CALC (edge k+5) -> answer=0, busy=0 immediately. No done. New start afterwards completes normally.
REQ-035 SIGNED_MODE_EN, sgn=1: a=16'hFFFD (-3), b=16'd5 -> answer=32'hFFFFFFF1. a=16'h8000, b=16'h8000 -> answer=32'h40000000. sgn=0 with the same a=16'hFFFD, b=16'd5 -> 32'h0004FFF1.
